stepdir_phase_sequencer: RTL

Multi-channel step/direction translator for A3988-class bipolar drivers. It converts asynchronous Step/Dir/MS1/MS2 inputs per motor into registered I0/I1/Phase controls for both coils. A 16-entry quarter-step electrical table is generalised over CHANNELS, with selectable step resolution, per-channel enable and an optional signed microstep position counter readable over a select/data port. It sits between the motion/PID logic (or external step sources) and the MotorPhase output pins.

---
 rtl/stepdir_phase_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/stepdir_phase_sequencer.sv
// stepdir_phase_sequencer: step/dir/MS inputs to registered A3988 I0/I1/Phase coil controls per motor.
// Define STEPDIR_POSITION_EN to build in the signed position counters and pos_data readback.
module stepdir_phase_sequencer #(
   parameter int CHANNELS    = 2,
   parameter int SYNC_STAGES = 2,
   parameter int POS_WIDTH   = 16
) (
   input  logic                                         clk,
   input  logic                                         reset_n,
   input  logic [CHANNELS-1:0]                          enable,
   input  logic [CHANNELS-1:0]                          step,
   input  logic [CHANNELS-1:0]                          dir,
   input  logic [CHANNELS-1:0]                          ms1,
   input  logic [CHANNELS-1:0]                          ms2,
   output logic [CHANNELS-1:0]                          coil_a_i0,
   output logic [CHANNELS-1:0]                          coil_a_i1,
   output logic [CHANNELS-1:0]                          coil_a_phase,
   output logic [CHANNELS-1:0]                          coil_b_i0,
   output logic [CHANNELS-1:0]                          coil_b_i1,
   output logic [CHANNELS-1:0]                          coil_b_phase,
   input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] pos_sel,
   output logic [POS_WIDTH-1:0]                         pos_data
);
   localparam int BW = 5 * CHANNELS;

   function automatic logic [2:0] inc(input logic m1, input logic m2);
      return m2 ? 3'd1 : m1 ? 3'd2 : 3'd4;
   endfunction

   function automatic logic [3:0] step_k(input logic [3:0] k, input logic d, input logic m1, input logic m2);
      logic [3:0] base;
      base = m2 ? k : m1 ? {k[3:1], 1'b0} : {k[3:2], 2'b10};
      return d ? base + 4'(inc(m1, m2)) : base - 4'(inc(m1, m2));
   endfunction

   function automatic logic [2:0] coil(input logic [3:0] k, input logic en);
      logic [2:0] j;
      logic [1:0] m;
      j = k[2:0];
      m = (j == 3'd4) ? 2'b11 : (j == 3'd3 || j == 3'd5) ? 2'b10 :
          (j == 3'd2 || j == 3'd6) ? 2'b01 : 2'b00;
      return {en ? m : 2'b11, ~(k[3] ^ k[2])};
   endfunction

   logic [BW-1:0]        sync_q [SYNC_STAGES];
   logic [BW-1:0]        sync_d [SYNC_STAGES];
   logic [CHANNELS-1:0]  prev_q, prev_d;
   logic [SYNC_STAGES:0] rdy_q, rdy_d;
   logic [3:0]           k_q [CHANNELS];
   logic [3:0]           k_d [CHANNELS];
   logic [2:0]           a_q [CHANNELS];
   logic [2:0]           a_d [CHANNELS];
   logic [2:0]           b_q [CHANNELS];
   logic [2:0]           b_d [CHANNELS];
   logic [CHANNELS-1:0]  step_s, dir_s, ms1_s, ms2_s, en_s, en_nx, acc;

   assign step_s = sync_q[SYNC_STAGES-1][0 +: CHANNELS];
   assign dir_s  = sync_q[SYNC_STAGES-1][CHANNELS +: CHANNELS];
   assign ms1_s  = sync_q[SYNC_STAGES-1][2*CHANNELS +: CHANNELS];
   assign ms2_s  = sync_q[SYNC_STAGES-1][3*CHANNELS +: CHANNELS];
   assign en_s   = sync_q[SYNC_STAGES-1][4*CHANNELS +: CHANNELS];
   // Output forcing follows the enable one stage early, so it tracks the synchronised enable on the same edge.
   assign en_nx  = sync_q[SYNC_STAGES-2][4*CHANNELS +: CHANNELS];
   // rdy_q marks when prev_q holds a real post-reset sample, so a step held high through reset is not an edge.
   assign acc    = step_s & ~prev_q & en_s & {CHANNELS{rdy_q[SYNC_STAGES]}};

   always_comb begin
      sync_d[0] = {enable, ms2, ms1, dir, step};
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      prev_d = step_s;
      rdy_d  = {rdy_q[SYNC_STAGES-1:0], 1'b1};
      for (int i = 0; i < CHANNELS; i++) begin
         k_d[i] = acc[i] ? step_k(k_q[i], dir_s[i], ms1_s[i], ms2_s[i]) : k_q[i];
         a_d[i] = coil(k_d[i], en_nx[i]);
         b_d[i] = coil(k_d[i] + 4'd12, en_nx[i]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
         rdy_q  <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            k_q[i] <= 4'd2;
            a_q[i] <= 3'b011;
            b_q[i] <= 3'b011;
         end
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
         prev_q <= prev_d;
         rdy_q  <= rdy_d;
         for (int i = 0; i < CHANNELS; i++) begin
            k_q[i] <= k_d[i];
            a_q[i] <= a_d[i];
            b_q[i] <= b_d[i];
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_out
      assign {coil_a_i1[c], coil_a_i0[c], coil_a_phase[c]} = a_q[c];
      assign {coil_b_i1[c], coil_b_i0[c], coil_b_phase[c]} = b_q[c];
   end

`ifdef STEPDIR_POSITION_EN
   logic [POS_WIDTH-1:0] pos_q [CHANNELS];
   logic [POS_WIDTH-1:0] pos_d [CHANNELS];
   logic [POS_WIDTH-1:0] pos_data_q, pos_data_d;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++)
         pos_d[i] = !acc[i] ? pos_q[i] :
                    dir_s[i] ? pos_q[i] + POS_WIDTH'(inc(ms1_s[i], ms2_s[i])) :
                               pos_q[i] - POS_WIDTH'(inc(ms1_s[i], ms2_s[i]));
      pos_data_d = (int'(pos_sel) < CHANNELS) ? pos_q[pos_sel] : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) pos_q[i] <= '0;
         pos_data_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) pos_q[i] <= pos_d[i];
         pos_data_q <= pos_data_d;
      end
   end

   assign pos_data = pos_data_q;
`else
   logic unused_sel;
   assign unused_sel = ^pos_sel;
   assign pos_data   = '0;
`endif
endmodule
